// File: rtl/smvm_stream_tx.sv
// Loads one sparse matrix and one dense vector, then on start streams them out with no gaps.
// Order is header, vector, val/col pairs, terminator; the header is driven the cycle after start and done one cycle after the terminator; no backpressure.
module smvm_stream_tx #(
    parameter int MAX_NNZ = 32,
    parameter int AW      = $clog2(MAX_NNZ)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    cfg_rows,
    input  logic [2:0]    cfg_cols,
    input  logic [AW:0]   nz_count,
    input  logic          start,
    input  logic          vec_wr_en,
    input  logic [2:0]    vec_wr_addr,
    input  logic [7:0]    vec_wr_data,
    input  logic          nz_wr_en,
    input  logic [AW-1:0] nz_wr_addr,
    input  logic [11:0]   nz_wr_data,
    output logic [7:0]    val_out,
    output logic [2:0]    col_out,
    output logic          ipv_out,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {IDLE, HDR, VEC, NZ_VAL, NZ_COL, TERM, FIN} state_t;

    state_t      state, state_n;
    logic [7:0]  vec_mem [8];
    logic [11:0] nz_mem  [MAX_NNZ];

    logic [7:0]  rows_q, rows_n;
    logic [2:0]  cols_q, cols_n;
    logic [AW:0] cnt_q, cnt_n;
    logic [2:0]  vec_idx, vec_idx_n, vec_idx_p1;
    logic [AW:0] nz_idx, nz_idx_n, nz_idx_p1, nz_next;
    logic [8:0]  rs_cnt, rs_cnt_n;
    logic        err_flag, err_flag_n;
    logic [7:0]  val_n;
    logic [2:0]  col_n;
    logic        ipv_n, busy_n, done_n, err_n;
    logic        nz_enter, cfg_bad;
    logic [AW-1:0] rd_addr;
    logic [11:0] ent;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++)       vec_mem[i] <= '0;
            for (int i = 0; i < MAX_NNZ; i++) nz_mem[i]  <= '0;
        end else if (state == IDLE) begin
            if (vec_wr_en) vec_mem[vec_wr_addr] <= vec_wr_data;
            if (nz_wr_en)  nz_mem[nz_wr_addr]   <= nz_wr_data;
        end
    end

    assign vec_idx_p1 = vec_idx + 3'd1;
    assign nz_idx_p1  = nz_idx + (AW+1)'(1);
    assign cfg_bad    = (cfg_rows == 8'd0) || (cfg_cols == 3'd0) || (nz_count == '0) ||
                        (nz_count > (AW+1)'(MAX_NNZ));

    // Entry n is needed while in NZ_VAL; entry n+1 (or 0) is looked ahead from NZ_COL / VEC.
    always_comb begin
        rd_addr = '0;
        if (state == NZ_VAL)      rd_addr = nz_idx[AW-1:0];
        else if (state == NZ_COL) rd_addr = nz_idx_p1[AW-1:0];
    end
    assign ent = nz_mem[rd_addr];

    always_comb begin
        state_n    = state;
        rows_n     = rows_q;
        cols_n     = cols_q;
        cnt_n      = cnt_q;
        vec_idx_n  = vec_idx;
        nz_idx_n   = nz_idx;
        rs_cnt_n   = rs_cnt;
        err_flag_n = err_flag;
        val_n      = 8'd0;
        col_n      = 3'd0;
        ipv_n      = 1'b0;
        busy_n     = 1'b0;
        done_n     = 1'b0;
        err_n      = 1'b0;
        nz_enter   = 1'b0;
        nz_next    = '0;
        case (state)
            IDLE: if (start) begin
                rows_n     = cfg_rows;
                cols_n     = cfg_cols;
                cnt_n      = nz_count;
                vec_idx_n  = 3'd0;
                nz_idx_n   = '0;
                rs_cnt_n   = 9'd0;
                err_flag_n = 1'b0;
                if (cfg_bad) begin
                    state_n = FIN;
                    done_n  = 1'b1;
                    err_n   = 1'b1;
                end else begin
                    state_n = HDR;
                    busy_n  = 1'b1;
                    val_n   = cfg_rows;
                    col_n   = cfg_cols;
                end
            end
            HDR: begin
                state_n   = VEC;
                busy_n    = 1'b1;
                vec_idx_n = 3'd0;
                val_n     = vec_mem[0];
            end
            VEC: begin
                busy_n = 1'b1;
                if ({1'b0, vec_idx} + 4'd1 < {1'b0, cols_q}) begin
                    vec_idx_n = vec_idx_p1;
                    val_n     = vec_mem[vec_idx_p1];
                end else begin
                    nz_enter = 1'b1;
                end
            end
            NZ_VAL: begin
                state_n = NZ_COL;
                busy_n  = 1'b1;
                col_n   = ent[10:8];
            end
            NZ_COL: begin
                busy_n = 1'b1;
                if (nz_idx_p1 == cnt_q) begin
                    state_n = TERM;
                end else begin
                    nz_enter = 1'b1;
                    nz_next  = nz_idx_p1;
                end
            end
            TERM: begin
                state_n = FIN;
                done_n  = 1'b1;
                err_n   = err_flag | (rs_cnt != {1'b0, rows_q});
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // A zero value would look like the terminator downstream, so cut the stream there.
        if (nz_enter) begin
            busy_n   = 1'b1;
            nz_idx_n = nz_next;
            if (ent[7:0] == 8'd0) begin
                state_n    = TERM;
                err_flag_n = 1'b1;
            end else begin
                state_n  = NZ_VAL;
                val_n    = ent[7:0];
                ipv_n    = ent[11];
                rs_cnt_n = rs_cnt + {8'd0, ent[11]};
                if (nz_next == '0 && !ent[11]) err_flag_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rows_q   <= '0;
            cols_q   <= '0;
            cnt_q    <= '0;
            vec_idx  <= '0;
            nz_idx   <= '0;
            rs_cnt   <= '0;
            err_flag <= 1'b0;
            val_out  <= '0;
            col_out  <= '0;
            ipv_out  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            rows_q   <= rows_n;
            cols_q   <= cols_n;
            cnt_q    <= cnt_n;
            vec_idx  <= vec_idx_n;
            nz_idx   <= nz_idx_n;
            rs_cnt   <= rs_cnt_n;
            err_flag <= err_flag_n;
            val_out  <= val_n;
            col_out  <= col_n;
            ipv_out  <= ipv_n;
            busy     <= busy_n;
            done     <= done_n;
            err      <= err_n;
        end
    end

endmodule

// File: tb/tb_smvm_stream_tx.sv
// Directed bench for smvm_stream_tx: nominal, bad config, zero entry, row mismatch, protection, reset, capacity.
module tb_smvm_stream_tx;
    localparam int MAX_NNZ = 32;
    localparam int AW      = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    cfg_rows;
    logic [2:0]    cfg_cols;
    logic [AW:0]   nz_count;
    logic          start;
    logic          vec_wr_en;
    logic [2:0]    vec_wr_addr;
    logic [7:0]    vec_wr_data;
    logic          nz_wr_en;
    logic [AW-1:0] nz_wr_addr;
    logic [11:0]   nz_wr_data;
    logic [7:0]    val_out;
    logic [2:0]    col_out;
    logic          ipv_out, busy, done, err;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];

    smvm_stream_tx #(.MAX_NNZ(MAX_NNZ), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .nz_count(nz_count), .start(start),
        .vec_wr_en(vec_wr_en), .vec_wr_addr(vec_wr_addr), .vec_wr_data(vec_wr_data),
        .nz_wr_en(nz_wr_en), .nz_wr_addr(nz_wr_addr), .nz_wr_data(nz_wr_data),
        .val_out(val_out), .col_out(col_out), .ipv_out(ipv_out),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] w(input logic ipv, input logic [2:0] c, input logic [7:0] v);
        return {ipv, c, v};
    endfunction

    task automatic wr_vec(input logic [2:0] a, input logic [7:0] d);
        vec_wr_en = 1'b1; vec_wr_addr = a; vec_wr_data = d;
        tick;
        vec_wr_en = 1'b0;
    endtask

    task automatic wr_nz(input logic [AW-1:0] a, input logic rs, input logic [2:0] c, input logic [7:0] v);
        nz_wr_en = 1'b1; nz_wr_addr = a; nz_wr_data = {rs, c, v};
        tick;
        nz_wr_en = 1'b0;
    endtask

    task automatic kick(input logic [7:0] r, input logic [2:0] c, input logic [AW:0] n);
        cfg_rows = r; cfg_cols = c; nz_count = n; start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    // Checks every queued word, then the done cycle; the caller advances past done.
    task automatic check_stream(input string tag, input logic exp_err);
        foreach (exp_q[i]) begin
            chk($sformatf("%s w%0d", tag, i), {busy, done, err, ipv_out, col_out, val_out},
                {3'b100, exp_q[i]});
            tick;
        end
        chk($sformatf("%s end", tag), {busy, done, err, ipv_out, col_out, val_out},
            {2'b01, exp_err, 12'd0});
    endtask

    task automatic load_nominal;
        wr_vec(3'd0, 8'h05); wr_vec(3'd1, 8'hFD); wr_vec(3'd2, 8'h02);
        wr_nz(5'd0, 1'b1, 3'd0, 8'h04);
        wr_nz(5'd1, 1'b0, 3'd2, 8'hFF);
        wr_nz(5'd2, 1'b1, 3'd1, 8'h07);
    endtask

    task automatic nominal_q(input logic [7:0] r);
        exp_q = '{w(0, 3'd3, r), w(0, 0, 8'h05), w(0, 0, 8'hFD), w(0, 0, 8'h02),
                  w(1, 0, 8'h04), w(0, 0, 8'h00), w(0, 0, 8'hFF), w(0, 3'd2, 8'h00),
                  w(1, 0, 8'h07), w(0, 3'd1, 8'h00), w(0, 0, 8'h00)};
    endtask

    initial begin
        logic [7:0]  bad_r [4];
        logic [2:0]  bad_c [4];
        logic [AW:0] bad_n [4];
        rst_n = 1'b0; cfg_rows = '0; cfg_cols = '0; nz_count = '0; start = 1'b0;
        vec_wr_en = 1'b0; vec_wr_addr = '0; vec_wr_data = '0;
        nz_wr_en = 1'b0; nz_wr_addr = '0; nz_wr_data = '0;
        #12;
        chk("reset", {busy, done, err, ipv_out, col_out, val_out}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick;

        load_nominal;
        kick(8'd2, 3'd3, 6'd3);
        nominal_q(8'd2);
        check_stream("nominal", 1'b0);
        tick;
        chk("nominal idle", {busy, done, err}, 32'd0);

        bad_r = '{8'd2, 8'd0, 8'd2, 8'd2};
        bad_c = '{3'd0, 3'd3, 3'd3, 3'd3};
        bad_n = '{6'd3, 6'd3, 6'd0, 6'd33};
        for (int k = 0; k < 4; k++) begin
            kick(bad_r[k], bad_c[k], bad_n[k]);
            chk($sformatf("badcfg%0d", k), {busy, done, err, ipv_out, col_out, val_out},
                {3'b011, 12'd0});
            tick;
            chk($sformatf("badcfg%0d after", k), {busy, done, err}, 32'd0);
        end

        wr_nz(5'd1, 1'b0, 3'd2, 8'h00);
        kick(8'd2, 3'd3, 6'd3);
        exp_q = '{w(0, 3'd3, 8'd2), w(0, 0, 8'h05), w(0, 0, 8'hFD), w(0, 0, 8'h02),
                  w(1, 0, 8'h04), w(0, 0, 8'h00), w(0, 0, 8'h00)};
        check_stream("zeroval", 1'b1);
        tick;
        wr_nz(5'd1, 1'b0, 3'd2, 8'hFF);

        kick(8'd3, 3'd3, 6'd3);
        nominal_q(8'd3);
        check_stream("rowmis", 1'b1);
        tick;

        kick(8'd2, 3'd3, 6'd3);
        start = 1'b1; cfg_rows = 8'd9;
        vec_wr_en = 1'b1; vec_wr_addr = 3'd0; vec_wr_data = 8'h55;
        nz_wr_en = 1'b1; nz_wr_addr = 5'd0; nz_wr_data = 12'h811;
        nominal_q(8'd2);
        check_stream("protect", 1'b0);
        start = 1'b0; vec_wr_en = 1'b0; nz_wr_en = 1'b0;
        tick;
        kick(8'd2, 3'd3, 6'd3);
        check_stream("replay", 1'b0);
        tick;

        kick(8'd2, 3'd3, 6'd3);
        repeat (4) tick;
        chk("pre-reset word", {busy, ipv_out, col_out, val_out}, {1'b1, w(1, 0, 8'h04)});
        #2 rst_n = 1'b0;
        #1;
        chk("async reset", {busy, done, err, ipv_out, col_out, val_out}, 32'd0);
        repeat (2) tick;
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk($sformatf("no done %0d", k), {busy, done, err}, 32'd0);
        end
        kick(8'd2, 3'd3, 6'd3);
        exp_q = '{w(0, 3'd3, 8'd2), w(0, 0, 0), w(0, 0, 0), w(0, 0, 0), w(0, 0, 0)};
        check_stream("cleared", 1'b1);
        tick;

        for (int i = 0; i < 7; i++) wr_vec(3'(i), 8'(i + 1));
        for (int k = 0; k < MAX_NNZ; k++) wr_nz(5'(k), (k % 4) == 0, 3'(k % 8), 8'(k + 1));
        kick(8'd8, 3'd7, 6'd32);
        exp_q = '{};
        exp_q.push_back(w(0, 3'd7, 8'd8));
        for (int i = 0; i < 7; i++) exp_q.push_back(w(0, 0, 8'(i + 1)));
        for (int k = 0; k < MAX_NNZ; k++) begin
            exp_q.push_back(w((k % 4) == 0, 0, 8'(k + 1)));
            exp_q.push_back(w(0, 3'(k % 8), 0));
        end
        exp_q.push_back(w(0, 0, 0));
        chk("capacity len", exp_q.size(), 32'd73);
        check_stream("capacity", 1'b0);
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/smvm_stream_tx.md
Name: smvm_stream_tx

Overview:
- Transmit side of the SMVM input stream: holds one sparse matrix (nonzero list) and one dense vector in local buffers, then serialises them onto the val/col/ipv stream consumed by the SMVM engine.
- Used as the on-chip stimulus source and bring-up driver in front of the SMVM core.
- A host writes the buffers, pulses start, and the block emits header, vector, nonzero pairs and terminator with no gaps.

Parameters:
MAX_NNZ, 32, nonzero buffer depth (power of two, 4..128)
AW, $clog2(MAX_NNZ), nonzero address width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous active-low
cfg_rows  in  8  row count, sampled at start
cfg_cols  in  3  column/vector length, sampled at start
nz_count  in  AW+1  number of nonzeros, sampled at start
start  in  1  one-cycle launch pulse
vec_wr_en  in  1  vector buffer write strobe
vec_wr_addr  in  3  vector index
vec_wr_data  in  8  signed vector element
nz_wr_en  in  1  nonzero buffer write strobe
nz_wr_addr  in  AW  nonzero index, row-major order
nz_wr_data  in  12  {row_start[11], col[10:8], val[7:0]}
val_out  out  8  stream value (to SMVM val_in)
col_out  out  3  stream column (to SMVM col_in)
ipv_out  out  1  stream row-start flag (to SMVM ipv_in)
busy  out  1  stream in progress
done  out  1  one-cycle pulse after terminator
err  out  1  one-cycle pulse, same cycle as done, on protocol error

Behaviour:
- Clock/reset: one clock clk. rst_n is asynchronous active-low.
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - Vector buffer (8x8) and nonzero buffer (MAX_NNZ x 12) cleared to 0.
- Reset mid-stream aborts immediately. No terminator is sent.
- Outputs are registered. When no word is being driven, val_out, col_out and ipv_out are 0.
- Buffer writes are accepted only in IDLE; they are ignored while busy.
- start is ignored while busy.
- States are IDLE, HDR, VEC, NZ_VAL, NZ_COL, TERM, FIN.
- IDLE:
  - On start, latch cfg_rows, cfg_cols and nz_count.
  - If cfg_rows==0, cfg_cols==0, nz_count==0 or nz_count>MAX_NNZ, go to FIN with error set. Nothing is streamed.
  - Otherwise go to HDR.
- HDR (1 cycle):
  - Drive val_out=rows, col_out=cols, ipv_out=0.
  - busy=1 from this cycle; the header appears the cycle after start.
- VEC (cols cycles, index 0..cols-1):
  - Drive val_out=vec[i], col_out=0, ipv_out=0.
  - Zero elements are legal because this phase is count-based.
- NZ_VAL:
  - Drive val_out=entry.val and ipv_out=entry.row_start for entry n.
  - If entry.val==0, drive nothing this cycle, set error and go to TERM (a zero would end the receiver's matrix phase early).
  - If n==0 and row_start==0, set error but continue.
- NZ_COL:
  - Drive val_out=0, col_out=entry.col, ipv_out=0.
  - Then n++. If n==nz_count go to TERM, else NZ_VAL.
- TERM (1 cycle): drive all zeros; this is the end-of-matrix marker. Go to FIN.
- FIN:
  - busy=0, done=1, err=error.
  - If row_start count != rows, err=1.
  - Return to IDLE; the next start is accepted from the following cycle.
- Stream length is 1 + cols + 2*nz_count + 1 cycles. done follows the terminator by 1 cycle.
- Width rules:
  - The row_start counter is 9 bits, so there is no wrap.
  - The nz index is AW+1 bits.
  - The vector index is 3 bits; cols max is 7.
- Buffers retain their contents after a stream, so restarting replays the same data.

Test Plan:
- Nominal stream, start at cycle t:
  - Setup: rows=2, cols=3, vec=[5,-3,2], nz={(s,c0,4),(c2,-1),(s,c1,7)}, nz_count=3.
  - t+1: header 2/3.
  - t+2..t+4: val 0x05, 0xFD, 0x02.
  - t+5: val 4, ipv 1. t+6: col 0.
  - t+7: val 0xFF, ipv 0. t+8: col 2.
  - t+9: val 7, ipv 1. t+10: col 1.
  - t+11: all zero (terminator).
  - t+12: done=1, err=0, busy=0.
- Bad config: cfg_cols=0 with start -> no stream, busy stays 0, done=err=1 at t+1.
- Zero-valued entry: nz[1].val=0 -> entry 0 pair sent, terminator sent in place of entry 1, err=1 with done.
- Row mismatch: rows=3 but only 2 row_start flags -> full stream emitted, err=1 with done.
- Protection and reset:
  - start and vec_wr_en asserted mid-stream -> ignored; a replay shows the original data.
  - rst_n low during NZ_VAL -> outputs 0 asynchronously, busy=0, no done.
- Capacity: nz_count=MAX_NNZ=32 with cols=7 -> 73-cycle stream, last pair from address 31, done=1, err=0.
